// File: rtl/even_parity_checker_sync.sv
// Registered even-parity checker for one DATA_W-bit word plus a received parity bit.
// Keeps saturating word/error counters, a sticky error flag and a consecutive-error alarm.
module even_parity_checker_sync #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ALARM_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              clear,
    output logic              valid_out,
    output logic              error,
    output logic              sticky_error,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic              alarm
);

    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] AlarmThr  = CNT_W'(ALARM_THRESH);

    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             sticky_q, sticky_d;
    logic             alarm_q, alarm_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] run_q, run_d;

    // Odd number of ones across data and parity means the word is bad.
    logic mismatch;
    assign mismatch = (^data_in) ^ parity_in;

    // Counter values after an optional clear, before this edge's word is counted.
    logic [CNT_W-1:0] word_base, err_base, run_base;
    logic             sticky_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CntMax) ? x : x + 1'b1;
    endfunction

    // Next-state: clear first, then fold in the accepted word so clear+valid restarts from it.
    always_comb begin
        valid_d     = 1'b0;
        error_d     = error_q;
        word_base   = clear ? '0 : word_q;
        err_base    = clear ? '0 : err_q;
        run_base    = clear ? '0 : run_q;
        sticky_base = clear ? 1'b0 : sticky_q;
        word_d      = word_base;
        err_d       = err_base;
        run_d       = run_base;
        sticky_d    = sticky_base;
        if (valid_in) begin
            valid_d  = 1'b1;
            error_d  = mismatch;
            word_d   = sat_inc(word_base);
            err_d    = mismatch ? sat_inc(err_base) : err_base;
            run_d    = mismatch ? sat_inc(run_base) : '0;
            sticky_d = sticky_base | mismatch;
        end
        alarm_d = (run_d >= AlarmThr);
    end

    // State registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
            alarm_q  <= 1'b0;
            word_q   <= '0;
            err_q    <= '0;
            run_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            error_q  <= error_d;
            sticky_q <= sticky_d;
            alarm_q  <= alarm_d;
            word_q   <= word_d;
            err_q    <= err_d;
            run_q    <= run_d;
        end
    end

    assign valid_out    = valid_q;
    assign error        = error_q;
    assign sticky_error = sticky_q;
    assign err_count    = err_q;
    assign word_count   = word_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_even_parity_checker_sync.sv
// Bench for even_parity_checker_sync: a wide-counter instance (threshold 3) and a 2-bit
// counter instance (threshold 1) share one stimulus stream and one reference model.
module tb_even_parity_checker_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [3:0] data_in;
    logic       parity_in;
    logic       clear;

    logic        v0, e0, s0, a0;
    logic [15:0] ec0, wc0;
    logic        v1, e1, s1, a1;
    logic [1:0]  ec1, wc1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, index 0 = wide instance, 1 = narrow instance.
    int m_words[2], m_errs[2], m_run[2], m_max[2], m_thr[2];
    bit m_sticky[2], m_err[2], m_vout[2];

    always #5 clk = ~clk;

    even_parity_checker_sync #(.DATA_W(4), .CNT_W(16), .ALARM_THRESH(3)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .parity_in(parity_in),
        .clear(clear), .valid_out(v0), .error(e0), .sticky_error(s0), .err_count(ec0),
        .word_count(wc0), .alarm(a0)
    );

    even_parity_checker_sync #(.DATA_W(4), .CNT_W(2), .ALARM_THRESH(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .parity_in(parity_in),
        .clear(clear), .valid_out(v1), .error(e1), .sticky_error(s1), .err_count(ec1),
        .word_count(wc1), .alarm(a1)
    );

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_words[i] = 0; m_errs[i] = 0; m_run[i] = 0;
            m_sticky[i] = 0; m_err[i] = 0; m_vout[i] = 0;
        end
    endtask

    // Word is bad when the total count of ones in data and parity is odd.
    task automatic model_edge(input bit v, input logic [3:0] d, input bit p, input bit c);
        int ones;
        bit bad;
        ones = p;
        for (int b = 0; b < 4; b++) ones += d[b];
        bad = (ones % 2) == 1;
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                m_words[i] = 0; m_errs[i] = 0; m_run[i] = 0; m_sticky[i] = 0;
            end
            m_vout[i] = v;
            if (v) begin
                m_err[i]   = bad;
                m_words[i] = sat(m_words[i] + 1, m_max[i]);
                if (bad) begin
                    m_errs[i]   = sat(m_errs[i] + 1, m_max[i]);
                    m_run[i]    = sat(m_run[i] + 1, m_max[i]);
                    m_sticky[i] = 1;
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_out0", 32'(v0), 32'(m_vout[0]));
        chk("error0", 32'(e0), 32'(m_err[0]));
        chk("sticky0", 32'(s0), 32'(m_sticky[0]));
        chk("err_count0", 32'(ec0), 32'(m_errs[0]));
        chk("word_count0", 32'(wc0), 32'(m_words[0]));
        chk("alarm0", 32'(a0), 32'(m_run[0] >= m_thr[0]));
        chk("valid_out1", 32'(v1), 32'(m_vout[1]));
        chk("error1", 32'(e1), 32'(m_err[1]));
        chk("sticky1", 32'(s1), 32'(m_sticky[1]));
        chk("err_count1", 32'(ec1), 32'(m_errs[1]));
        chk("word_count1", 32'(wc1), 32'(m_words[1]));
        chk("alarm1", 32'(a1), 32'(m_run[1] >= m_thr[1]));
    endtask

    // Drive one cycle's inputs, take the edge, then compare 1 time unit later.
    task automatic step(input bit v, input logic [3:0] d, input bit p, input bit c);
        valid_in = v; data_in = d; parity_in = p; clear = c;
        @(posedge clk);
        #1;
        model_edge(v, d, p, c);
        check_all();
    endtask

    initial begin
        m_max[0] = 65535; m_thr[0] = 3;
        m_max[1] = 3;     m_thr[1] = 1;
        model_reset();
        rst = 1'b1; valid_in = 1'b1; data_in = 4'hF; parity_in = 1'b1; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic words.
        step(1, 4'b1010, 1, 0);
        step(1, 4'b1111, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0101, 0, 0);
        chk("plan_word_count", 32'(wc0), 32'd4);
        chk("plan_err_count", 32'(ec0), 32'd1);
        chk("plan_sticky", 32'(s0), 32'd1);
        chk("plan_alarm", 32'(a0), 32'd0);

        // Alarm after three consecutive bad words, dropped by a good one.
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 0);
        chk("alarm_early", 32'(a0), 32'd0);
        step(1, 4'b0001, 0, 0);
        chk("alarm_set", 32'(a0), 32'd1);
        step(1, 4'b0011, 0, 0);
        chk("alarm_clr", 32'(a0), 32'd0);
        chk("sticky_held", 32'(s0), 32'd1);

        // Gaps: run must survive idle cycles between bad words.
        step(1, 4'b0001, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0111, 0, 0);
        step(0, 4'b1111, 1, 0);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b1000, 0, 0);
        chk("alarm_gap", 32'(a0), 32'd1);

        // Clear with and without a simultaneous word.
        step(1, 4'b0001, 0, 1);
        chk("clr_word_count", 32'(wc0), 32'd1);
        chk("clr_err_count", 32'(ec0), 32'd1);
        step(0, 4'b0000, 0, 1);
        chk("clr_idle_words", 32'(wc0), 32'd0);

        // Saturation on the 2-bit instance.
        repeat (5) step(1, 4'b0001, 0, 0);
        chk("sat_word_count", 32'(wc1), 32'd3);
        chk("sat_err_count", 32'(ec1), 32'd3);

        // Asynchronous reset between edges while a word is in flight.
        valid_in = 1'b1; data_in = 4'b0001; parity_in = 1'b0; clear = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'b0110, 1, 0);
        chk("post_rst_words", 32'(wc0), 32'd1);

        // Random traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(3) != 0), 4'($urandom), 1'($urandom),
                 ($urandom_range(15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
